// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one req/ack memory fetch at a time, holds the word for decode.
// Latency: ack in FETCH cycle N -> instr_valid in N+1; peak one instruction per 2 cycles.
// Backpressure: stalls in HOLD until instr_ready or redirect; memory stalls by withholding imem_ack.
module fetch_sequencer #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] STEP     = PC_W'(4)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic [31:0]       instr_q, instr_d;
  logic [PC_W-1:0]   instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; redirect outranks ack/ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_ack && !redirect_valid) begin
          state_d = HOLD;
        end else if (!imem_ack && redirect_valid) begin
          // request still outstanding: must wait for its ack before moving
          state_d = DRAIN;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD:  if (redirect_valid || instr_ready) state_d = FETCH;
      DRAIN: if (imem_ack) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values for the current state
  always_comb begin
    pc_d       = pc_q;
    target_d   = target_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (redirect_valid) pc_d = redirect_pc;
      end
      FETCH: begin
        if (redirect_valid) begin
          // address must stay at the old pc while a request is open,
          // so an unacked redirect is parked in target until the drain
          if (imem_ack) pc_d = redirect_pc;
          else          target_d = redirect_pc;
        end else if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + STEP;
          valid_d    = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
        end else if (instr_ready) begin
          valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          pc_d = redirect_valid ? redirect_pc : target_q;
        end else if (redirect_valid) begin
          target_d = redirect_pc;
        end
      end
      default: ;
    endcase
    // req is registered from the state we are entering so it lines up with imem_addr
    req_d = (state_d == FETCH) || (state_d == DRAIN);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      target_q   <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      target_q   <= target_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction-fetch controller for the 10-bit program counter. It owns the PC register and issues one request at a time to an instruction memory through a req/ack handshake. It holds each fetched word for decode through a valid/ready handshake and applies branch/jump redirects from decode. It sits between instruction memory and decode, and it replaces free-running PC advance once memory latency is no longer fixed at one cycle.

## Interface

- PC_W, 10, width of PC and memory address
- RESET_PC, 10'd0, PC value loaded on reset
- STEP, 10'd4, sequential PC increment

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  PC_W  fetch address, equal to current PC
- imem_ack  in  1  memory completes the outstanding request this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- instr_valid  out  1  instr/instr_pc hold a fetched instruction
- instr  out  32  fetched instruction word
- instr_pc  out  PC_W  address the held instruction was fetched from
- instr_ready  in  1  decode accepts instr this cycle when instr_valid=1
- redirect_valid  in  1  branch/jump taken, load new PC
- redirect_pc  in  PC_W  redirect target

## Operation

- The block has one clock and a synchronous, active-low reset. All outputs are registered.
- The state machine has four states: IDLE, FETCH, HOLD and DRAIN.
- **Reset (rst_n=0)** sets the following regardless of state:
  - state=IDLE, pc=RESET_PC
  - imem_req=0, imem_addr=RESET_PC
  - instr_valid=0, instr=0, instr_pc=0
- **IDLE** always moves to FETCH on the next cycle.
  - If redirect_valid=1, pc<=redirect_pc first.
- **FETCH**: imem_req=1 and imem_addr=pc.
  - With no ack and no redirect, the block stays in FETCH. Address and req are held stable.
  - imem_ack=1, no redirect:
    - instr<=imem_rdata, instr_pc<=pc
    - pc<=pc+STEP
    - instr_valid<=1, imem_req<=0, go to HOLD
  - imem_ack=1 with redirect_valid=1: the returned word is discarded and pc<=redirect_pc. The block stays in FETCH, and the new address appears next cycle with req held high.
  - imem_ack=0 with redirect_valid=1: pc_target<=redirect_pc and the block goes to DRAIN. imem_addr stays at the old pc until the outstanding request completes.
- **HOLD**: instr_valid=1 and imem_req=0.
  - instr_ready=1: instr_valid<=0 and the block goes to FETCH.
  - redirect_valid=1: instr_valid<=0, pc<=redirect_pc and the block goes to FETCH, whatever instr_ready is. If instr_ready=1 in the same cycle, the instruction counts as accepted.
  - Neither asserted: the block holds, and all outputs stay stable.
- **DRAIN**: imem_req=1 at the old address.
  - A further redirect overwrites pc_target; the last redirect wins.
  - On imem_ack=1 the data is discarded, pc<=pc_target (or redirect_pc if a redirect arrives the same cycle) and the block goes to FETCH.
- **Arithmetic**: pc+STEP is modulo 2^PC_W, so 1020+4 wraps to 0. redirect_pc is loaded unmodified, with no alignment forced.
- The word on imem_rdata never reaches instr while imem_ack=0.

## Timing

- Fetch latency: FETCH entered in cycle N with ack in N gives instr_valid=1 in N+1. Each cycle of delayed ack adds one cycle.
- Peak throughput is one instruction per 2 cycles, alternating FETCH and HOLD, with ack immediate and ready always high.
- Redirect to first request at the target:
  - from HOLD or FETCH with ack: 1 cycle
  - from FETCH without ack: 1 cycle after the ack that drains the request
- Reset release: IDLE in cycle 0, first imem_req=1 in cycle 1.
- Asserting rst_n=0 mid-fetch abandons the outstanding request with no drain. Memory must tolerate req dropping without ack.
- Priority order: rst_n, then redirect_valid, then imem_ack/instr_ready.

## Test plan

- **Sequential fetch**: reset then release, ack every cycle req is high, instr_ready=1 → addresses 0,4,8,12 on alternate cycles; instr_pc matches; instr_valid pulses 1 cycle each.
- **Wait states and backpressure**: ack 3 cycles after req, instr_ready low 2 cycles → imem_addr stable for 3 cycles; instr/instr_pc stable while valid and not ready; next fetch only after ready.
- **Redirect in HOLD**: holding instr from 0x008, redirect_pc=0x100 → instr_valid=0 next cycle, next imem_addr=0x100, then 0x104.
- **Redirect during outstanding fetch**: req at 0x010 unacked, redirect to 0x200, then a second redirect to 0x300 before ack, ack with rdata=0xDEADBEEF → word never presented; next imem_addr=0x300.
- **Redirect coincident with ack**: ack at 0x020 with redirect to 0x040 → word discarded; imem_addr=0x040 next cycle, req stays high.
- **Wrap and reset mid-op**: run to pc=1020 then ack → next imem_addr=0. Then pull rst_n low while waiting in FETCH → next cycle imem_req=0, instr_valid=0, imem_addr=RESET_PC.
